// File: rtl/hack_clock_gen.sv
// Programmable Hack CPU clock generator: derives hack_clk from clk with a runtime half-period,
// run/stop and single-step control, and registered rise/fall/toggle strobes.
module hack_clock_gen #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic [CNT_W-1:0] half_period,
  input  logic             load,
  output logic             hack_clk,
  output logic             strobe,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic             busy,
  output logic             step_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pflag_q, pflag_d;
  logic             hclk_q, hclk_d;
  logic             strobe_q, strobe_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             sdone_q, sdone_d;
  logic             toggle_s;

  // Toggle point: only meaningful while the clock is being generated.
  assign toggle_s = (state_q != S_IDLE) && (cnt_q == term_q);

  // Next-state, counter, divider-load and strobe logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    hclk_d   = hclk_q;
    strobe_d = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    sdone_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = CNT_ZERO;
        hclk_d = 1'b0;
        if (load) begin
          term_d = half_period;
        end else begin
          term_d = term_q;
        end
        if (run) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN, S_STEP: begin
        if (toggle_s) begin
          // A pending divider only lands here, when the counter restarts from zero.
          cnt_d    = CNT_ZERO;
          hclk_d   = ~hclk_q;
          strobe_d = 1'b1;
          rise_d   = ~hclk_q;
          fall_d   = hclk_q;
          if (pflag_q) begin
            term_d  = pend_q;
            pflag_d = 1'b0;
          end else begin
            term_d  = term_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end

        if (load) begin
          pend_d  = half_period;
          pflag_d = 1'b1;
        end else begin
          pend_d  = pend_q;
        end

        if (state_q == S_RUN) begin
          if (toggle_s && hclk_q && !run) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          if (run) begin
            state_d = S_RUN;
          end else if (toggle_s && hclk_q) begin
            state_d = S_IDLE;
            sdone_d = 1'b1;
          end else begin
            state_d = S_STEP;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        hclk_d  = 1'b0;
        pflag_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any half-period in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      term_q   <= CNT_W'(DEFAULT_HALF);
      pend_q   <= CNT_ZERO;
      pflag_q  <= 1'b0;
      hclk_q   <= 1'b0;
      strobe_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      sdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      term_q   <= term_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      hclk_q   <= hclk_d;
      strobe_q <= strobe_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      sdone_q  <= sdone_d;
    end
  end

  assign hack_clk    = hclk_q;
  assign strobe      = strobe_q;
  assign rise_strobe = rise_q;
  assign fall_strobe = fall_q;
  assign busy        = busy_q;
  assign step_done   = sdone_q;

endmodule

// File: tb/tb_hack_clock_gen.sv
// Directed self-checking bench for hack_clock_gen with hand-computed edge counts.
module tb_hack_clock_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] half_period = 8'd0;
  logic       load = 1'b0;
  logic       hack_clk, strobe, rise_strobe, fall_strobe, busy, step_done;

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0;
  int sd_base = 0;
  int n = 0;

  hack_clock_gen #(.CNT_W(8), .DEFAULT_HALF(18)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .half_period(half_period), .load(load),
    .hack_clk(hack_clk), .strobe(strobe), .rise_strobe(rise_strobe),
    .fall_strobe(fall_strobe), .busy(busy), .step_done(step_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_done === 1'b1) sd_cnt <= sd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges until the next strobe; 999 if none appears within the budget.
  task automatic wait_strobe(output int cnt);
    cnt = 999;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (strobe === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset values, released with run already high
    run = 1'b1;
    #3;
    chk("rst_hclk", {31'd0, hack_clk}, 32'd0);
    chk("rst_strb", {28'd0, strobe, rise_strobe, fall_strobe, step_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_hclk0", {31'd0, hack_clk}, 32'd0);
    wait_strobe(n);
    chk("first_rise_n", n, 32'd19);
    chk("first_rise", {29'd0, hack_clk, rise_strobe, fall_strobe}, 32'b110);
    wait_strobe(n);
    chk("first_fall_n", n, 32'd19);
    chk("first_fall", {29'd0, hack_clk, rise_strobe, fall_strobe}, 32'b001);

    // Runtime load mid-half-period
    repeat (5) tick();
    half_period = 8'd3; load = 1'b1;
    tick();
    load = 1'b0;
    wait_strobe(n);
    chk("old_half_done", n, 32'd13);
    wait_strobe(n);
    chk("new_half_fall", n, 32'd4);
    wait_strobe(n);
    chk("new_half_rise", n, 32'd4);
    half_period = 8'd0; load = 1'b1;
    tick();
    load = 1'b0;
    wait_strobe(n);
    chk("pre_zero_fall", n, 32'd3);
    wait_strobe(n);
    chk("zero_rise", n, 32'd1);
    wait_strobe(n);
    chk("zero_fall", n, 32'd1);

    // Back to term=4 while toggling every cycle
    half_period = 8'd4; load = 1'b1;
    tick();
    load = 1'b0;
    chk("t0_rise", {30'd0, hack_clk, rise_strobe}, 32'b11);
    tick();
    chk("t0_fall", {30'd0, hack_clk, fall_strobe}, 32'b01);
    wait_strobe(n);
    chk("t4_rise", n, 32'd5);

    // Stop on fall
    run = 1'b0;
    wait_strobe(n);
    chk("stop_fall_n", n, 32'd5);
    chk("stop_state", {29'd0, hack_clk, fall_strobe, busy}, 32'b010);
    repeat (3) tick();
    chk("idle_hold", {29'd0, hack_clk, strobe, busy}, 32'd0);

    // Drop and re-raise run while high: no stop
    run = 1'b1;
    tick();
    wait_strobe(n);
    chk("glitch_rise", n, 32'd5);
    run = 1'b0;
    repeat (2) tick();
    run = 1'b1;
    wait_strobe(n);
    chk("glitch_fall_n", n, 32'd3);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    wait_strobe(n);
    chk("glitch_rise2", n, 32'd5);
    run = 1'b0;
    wait_strobe(n);
    chk("glitch_stop", {30'd0, fall_strobe, busy}, 32'b10);

    // Single step with an extra ignored step pulse
    tick();
    sd_base = sd_cnt;
    step = 1'b1;
    tick();
    chk("step_busy", {31'd0, busy}, 32'd1);
    tick();
    step = 1'b0;
    wait_strobe(n);
    chk("step_rise", n, 32'd4);
    chk("step_rise_sd", {30'd0, rise_strobe, step_done}, 32'b10);
    wait_strobe(n);
    chk("step_fall_n", n, 32'd5);
    chk("step_done", {28'd0, step_done, fall_strobe, busy, hack_clk}, 32'b1100);
    tick();
    chk("step_after", {29'd0, step_done, busy, hack_clk}, 32'd0);
    chk("step_once", sd_cnt - sd_base, 32'd1);

    // run+step together: run wins
    sd_base = sd_cnt;
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    wait_strobe(n);
    chk("prio_rise", n, 32'd5);
    run = 1'b0;
    wait_strobe(n);
    chk("prio_fall", {30'd0, fall_strobe, busy}, 32'b10);
    chk("prio_no_sd", sd_cnt - sd_base, 32'd0);

    // run raised during STEP continues free-running
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (2) tick();
    run = 1'b1;
    tick();
    wait_strobe(n);
    chk("s2r_rise", n, 32'd2);
    wait_strobe(n);
    chk("s2r_fall", {30'd0, fall_strobe, busy}, 32'b11);
    wait_strobe(n);
    chk("s2r_rise2", n, 32'd5);
    chk("s2r_no_sd", sd_cnt - sd_base, 32'd0);

    // Load term=10, then async reset with hack_clk=1, counter=7
    half_period = 8'd10; load = 1'b1;
    tick();
    load = 1'b0;
    wait_strobe(n);
    chk("l10_fall", n, 32'd4);
    wait_strobe(n);
    chk("l10_rise", n, 32'd11);
    repeat (7) tick();
    chk("pre_rst_hclk", {31'd0, hack_clk}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {26'd0, hack_clk, strobe, rise_strobe, fall_strobe, busy, step_done}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    wait_strobe(n);
    chk("rst_term18", n, 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
